alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched.sv | 122 ++++++++++++
 tb/tb_alu_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-requester scheduler for one shared 8-bit ALU. Each operation runs IDLE -> EXEC -> RESP.
// Define ALU_SCHED_RR_EN for round-robin arbitration; without it, requester 0 has fixed priority.
module alu_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] op0,
  input  logic [3:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res,
  output logic [3:0] flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_r,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       winner;
  logic       pick1;
  logic [3:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;

`ifdef ALU_SCHED_RR_EN
  logic last_gnt;

  // On a tie, requester 1 wins only when requester 0 was granted last.
  always_comb begin
    pick1 = req1 & (~req0 | ~last_gnt);
  end
`else
  always_comb begin
    pick1 = req1 & ~req0;
  end
`endif

  always_comb begin
    state_nxt = IDLE;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt0      = ~pick1;
          gnt1      = pick1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        done0     = ~winner;
        done1     = winner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Handshake outputs stay quiet for the whole reset.
    if (rst) begin
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      done0 = 1'b0;
      done1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      winner <= 1'b0;
      op_q   <= 4'd0;
      a_q    <= 8'd0;
      b_q    <= 8'd0;
      res    <= 8'd0;
      flags  <= 4'd0;
`ifdef ALU_SCHED_RR_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (gnt0 | gnt1) begin
        winner <= gnt1;
        op_q   <= gnt1 ? op1 : op0;
        a_q    <= gnt1 ? a1 : a0;
        b_q    <= gnt1 ? b1 : b0;
`ifdef ALU_SCHED_RR_EN
        last_gnt <= gnt1;
`endif
      end
      if (state == EXEC) begin
        res   <= alu_r;
        flags <= {alu_c, alu_z, alu_v, alu_n};
      end
    end
  end

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small behavioural ALU on the alu_* ports.
// Tie-order expectations follow ALU_SCHED_RR_EN, which must match the RTL build.
module tb_alu_sched;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [3:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] res;
  logic [3:0] flags;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_r;
  logic       alu_c, alu_z, alu_v, alu_n;

  int errors = 0;
  int checks = 0;

  alu_sched dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .flags(flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode {k,i,j,c_in}: k=0 computes a + y + c_in, where y is chosen by {i,j} as 0, FF, b or ~b; k=1 is logic.
  logic [7:0] alu_y;
  logic [8:0] alu_sum;
  always_comb begin
    alu_y   = alu_op[2] ? (alu_op[1] ? ~alu_b : alu_b) : (alu_op[1] ? 8'hFF : 8'h00);
    alu_sum = {1'b0, alu_a} + {1'b0, alu_y} + {8'd0, alu_op[0]};
    alu_r   = alu_sum[7:0];
    alu_c   = alu_sum[8];
    alu_v   = (alu_a[7] == alu_y[7]) && (alu_sum[7] != alu_a[7]);
    if (alu_op[3]) begin
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (alu_op[2:1])
        2'b00:   alu_r = alu_a & alu_b;
        2'b01:   alu_r = alu_a | alu_b;
        2'b10:   alu_r = alu_a ^ alu_b;
        default: alu_r = ~alu_a;
      endcase
    end
    alu_z = (alu_r == 8'd0);
    alu_n = alu_r[7];
  end

  // Advance one cycle and drive the new inputs just after the edge.
  task automatic applyStimulus(input logic r, input logic q0, input logic q1);
    @(posedge clk);
    #1;
    rst  = r;
    req0 = q0;
    req1 = q1;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic exp_w1;
  logic [7:0] exp_res;

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 4'd0; op1 = 4'd0;
    a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;

    // Reset: a pending request must not be granted while rst is high.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rst_gnt0", {7'd0, gnt0}, 8'd0);
    checkOutput("rst_done", {6'd0, done0, done1}, 8'd0);
    checkOutput("rst_res", res, 8'h00);
    checkOutput("rst_flags", {4'd0, flags}, 8'h00);
    checkOutput("rst_alu_a", alu_a, 8'h00);

    // Requester 0 alone: 5 + 3.
    op0 = 4'b0100; a0 = 8'h05; b0 = 8'h03;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("solo0_gnt", {6'd0, gnt0, gnt1}, 8'b10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("solo0_exec_gnt", {6'd0, gnt0, done0}, 8'd0);
    checkOutput("solo0_alu_a", alu_a, 8'h05);
    checkOutput("solo0_alu_b", alu_b, 8'h03);
    checkOutput("solo0_alu_op", {4'd0, alu_op}, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("solo0_done", {6'd0, done0, done1}, 8'b10);
    checkOutput("solo0_res", res, 8'h08);
    checkOutput("solo0_flags", {4'd0, flags}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("solo0_done_clr", {6'd0, done0, done1}, 8'd0);
    checkOutput("solo0_res_hold", res, 8'h08);
    checkOutput("solo0_alu_a_hold", alu_a, 8'h05);

    // Requester 1 alone: 3 - 3 gives zero with carry out.
    op1 = 4'b0111; a1 = 8'h03; b1 = 8'h03;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("solo1_gnt", {6'd0, gnt0, gnt1}, 8'b01);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("solo1_done", {6'd0, done0, done1}, 8'b01);
    checkOutput("solo1_res", res, 8'h00);
    checkOutput("solo1_flags", {4'd0, flags}, 8'b1100);

    // Both held for four operations. Requester 1 was granted last, so requester 0 takes the first tie.
    op0 = 4'b0100; a0 = 8'h01; b0 = 8'h01;
    op1 = 4'b0100; a1 = 8'h10; b1 = 8'h20;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_SCHED_RR_EN
      exp_w1 = k[0];
`else
      exp_w1 = 1'b0;
`endif
      exp_res = exp_w1 ? 8'h30 : 8'h02;
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("tie%0d_gnt", k), {6'd0, gnt0, gnt1}, {6'd0, ~exp_w1, exp_w1});
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("tie%0d_exec_nognt", k), {6'd0, gnt0, gnt1}, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("tie%0d_resp", k), {4'd0, gnt0, gnt1, done0, done1},
                  {6'd0, ~exp_w1, exp_w1});
      checkOutput($sformatf("tie%0d_res", k), res, exp_res);
    end

    // Reset while EXEC aborts the operation.
    op0 = 4'b0100; a0 = 8'h05; b0 = 8'h03;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort_gnt", {6'd0, gnt0, gnt1}, 8'b10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_no_done", {6'd0, done0, done1}, 8'd0);
    checkOutput("abort_res", res, 8'h00);
    checkOutput("abort_flags", {4'd0, flags}, 8'h00);
    checkOutput("abort_alu_a", alu_a, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_no_done_late", {6'd0, done0, done1}, 8'd0);

    // First tie after reset goes to requester 0; 7F + 01 overflows into the sign bit.
    op0 = 4'b0100; a0 = 8'h7F; b0 = 8'h01;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("post_rst_gnt", {6'd0, gnt0, gnt1}, 8'b10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_done", {6'd0, done0, done1}, 8'b10);
    checkOutput("post_rst_res", res, 8'h80);
    checkOutput("post_rst_flags", {4'd0, flags}, 8'b0011);

    // Requester 1 raises and drops its request while requester 0 is busy.
    op0 = 4'b0100; a0 = 8'h02; b0 = 8'h02;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("drop_gnt0", {6'd0, gnt0, gnt1}, 8'b10);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("drop_exec_nognt1", {7'd0, gnt1}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drop_done0", {6'd0, done0, done1}, 8'b10);
    checkOutput("drop_res", res, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drop_idle_nognt1", {6'd0, gnt0, gnt1}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drop_no_done1", {6'd0, done0, done1}, 8'd0);
    checkOutput("drop_res_hold", res, 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
